// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared I2S definitions for the transmit and receive paths
//
// Purpose : common constants and types for the I2S blocks.
//   TIDW      : width of the stream channel id (tid) bus
//   ch_e      : slot/channel encoding; matches the lrclk level of the slot
//   cnt_width : counter width helper that never returns zero
package i2s_pkg;

   localparam int TIDW = 8;

   typedef enum logic {
      CH_LEFT  = 1'b0,
      CH_RIGHT = 1'b1
   } ch_e;

   // $clog2(1) is 0, which would give a zero-width counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - I2S bit clock, word select and slot bit counter
//
// Purpose : divides clk down to sclk, produces the falling-edge strobe on
//           which every lrclk/sdo change happens, and tracks the slot bit
//           index b.
// Ports   :
//   clk       in   master clock, all logic on its rising edge
//   rst       in   asynchronous active-high reset
//   sclk      out  bit clock, clk/(2*SCLK_DIV), 50% duty
//   lrclk     out  word select, 0 = left slot, 1 = right slot
//   strobe    out  high in the clk cycle whose rising edge drives sclk 1->0
//   bit_next  out  value b takes at the coming strobe (0 means a new slot)
module i2s_clkgen
   import i2s_pkg::*;
#(
   parameter int FRAME_BITS = 32,
   parameter int SCLK_DIV   = 4,
   localparam int BW        = cnt_width(FRAME_BITS)
) (
   input  logic          clk,
   input  logic          rst,
   output logic          sclk,
   output logic          lrclk,
   output logic          strobe,
   output logic [BW-1:0] bit_next
);

   localparam int DVW = cnt_width(SCLK_DIV);
   localparam logic [DVW-1:0] DIV_LAST = DVW'(SCLK_DIV - 1);
   localparam logic [BW-1:0]  B_LAST   = BW'(FRAME_BITS - 1);

   if (SCLK_DIV < 1) begin : g_bad_div
      $error("i2s_clkgen: SCLK_DIV must be at least 1");
   end

   logic [DVW-1:0] div;
   logic [BW-1:0]  bit_idx;
   logic           tc;

   assign tc       = (div == DIV_LAST);
   // sclk is about to fall only when it is currently high at terminal count.
   assign strobe   = tc & sclk;
   assign bit_next = (bit_idx == B_LAST) ? '0 : bit_idx + 1'b1;

   // b resets to its last value so the first strobe wraps it to 0 and
   // flips lrclk from 1 to 0, opening a left slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div     <= '0;
         sclk    <= 1'b0;
         lrclk   <= 1'b1;
         bit_idx <= B_LAST;
      end else begin
         div <= tc ? '0 : div + 1'b1;
         if (tc) begin
            sclk <= ~sclk;
         end
         if (strobe) begin
            bit_idx <= bit_next;
            if (bit_next == '0) begin
               lrclk <= ~lrclk;
            end
         end
      end
   end

endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmitter with per-channel sample holding registers
//
// Purpose : accepts samples on a tid-tagged stream, buffers one per channel
//           and serialises them MSB first with the one-bit I2S delay.
// Ports   :
//   clk            in   master clock
//   rst            in   asynchronous active-high reset
//   s_axis_tdata   in   sample (DW bits)
//   s_axis_tvalid  in   sample valid
//   s_axis_tready  out  target channel holding register is empty
//   s_axis_tid     in   bit 0 selects left (0) / right (1); rest ignored
//   sclk           out  I2S bit clock
//   lrclk          out  I2S word select, 0 = left
//   sdo            out  I2S serial data, changes with sclk falling
//   underflow      out  one-clk pulse when a slot opens with no sample
module i2s_tx
   import i2s_pkg::*;
#(
   parameter int DW         = 24,
   parameter int FRAME_BITS = 32,
   parameter int SCLK_DIV   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   s_axis_tdata,
   input  logic            s_axis_tvalid,
   output logic            s_axis_tready,
   input  logic [TIDW-1:0] s_axis_tid,
   output logic            sclk,
   output logic            lrclk,
   output logic            sdo,
   output logic            underflow
);

   localparam int BW = cnt_width(FRAME_BITS);

   if (FRAME_BITS <= DW) begin : g_bad_frame
      $error("i2s_tx: FRAME_BITS must be greater than DW");
   end

   logic          strobe;
   logic [BW-1:0] bit_next;
   logic          load;
   logic          accept;
   ch_e           wr_ch;
   ch_e           ld_ch;
   logic [1:0]    full;
   logic [DW-1:0] hold [2];
   logic [DW-1:0] shreg;
   logic          unused_tid;

   i2s_clkgen #(
      .FRAME_BITS (FRAME_BITS),
      .SCLK_DIV   (SCLK_DIV)
   ) u_clkgen (
      .clk      (clk),
      .rst      (rst),
      .sclk     (sclk),
      .lrclk    (lrclk),
      .strobe   (strobe),
      .bit_next (bit_next)
   );

   assign unused_tid    = ^s_axis_tid[TIDW-1:1];
   assign wr_ch         = ch_e'(s_axis_tid[0]);
   // At a wrapping strobe lrclk is about to flip, so the slot being opened
   // belongs to the opposite of the current lrclk level.
   assign ld_ch         = ch_e'(~lrclk);
   assign s_axis_tready = ~full[wr_ch];
   assign accept        = s_axis_tvalid & s_axis_tready;
   assign load          = strobe & (bit_next == '0);

   // The accept update is written after the load update so that when both
   // hit the same channel in one cycle the new sample wins the full flag and
   // survives for that channel's next slot, while this slot sends zeros.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full      <= '0;
         hold[0]   <= '0;
         hold[1]   <= '0;
         shreg     <= '0;
         sdo       <= 1'b0;
         underflow <= 1'b0;
      end else begin
         underflow <= 1'b0;
         if (load) begin
            // b = 0 carries the I2S delay bit, always zero.
            shreg       <= full[ld_ch] ? hold[ld_ch] : '0;
            underflow   <= ~full[ld_ch];
            full[ld_ch] <= 1'b0;
            sdo         <= 1'b0;
         end else if (strobe) begin
            // b = 1..DW shift the sample out MSB first; padding bits are 0.
            if (bit_next <= BW'(DW)) begin
               sdo   <= shreg[DW-1];
               shreg <= shreg << 1;
            end else begin
               sdo <= 1'b0;
            end
         end
         if (accept) begin
            hold[wr_ch] <= s_axis_tdata;
            full[wr_ch] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed self-checking bench for i2s_tx
module tb_i2s_tx;
   import i2s_pkg::*;

   localparam int DW = 24;
   localparam int FB = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [DW-1:0]   tdata;
   logic            tvalid;
   logic [TIDW-1:0] tid;
   logic            tready, sclk, lrclk, sdo, underflow;
   logic            tready2, sclk2, lrclk2, sdo2, underflow2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   i2s_tx #(.DW(DW), .FRAME_BITS(FB), .SCLK_DIV(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (tdata),
      .s_axis_tvalid (tvalid),
      .s_axis_tready (tready),
      .s_axis_tid    (tid),
      .sclk          (sclk),
      .lrclk         (lrclk),
      .sdo           (sdo),
      .underflow     (underflow)
   );

   i2s_tx #(.DW(DW), .FRAME_BITS(FB), .SCLK_DIV(1)) dut2 (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (24'd0),
      .s_axis_tvalid (1'b0),
      .s_axis_tready (tready2),
      .s_axis_tid    (8'd0),
      .sclk          (sclk2),
      .lrclk         (lrclk2),
      .sdo           (sdo2),
      .underflow     (underflow2)
   );

   // Slot deserialiser: captures sdo on each sclk rise, starting a slot at
   // the first rise after lrclk changes (b = 0), and records underflow
   // pulses seen just before each slot opened.
   logic [31:0] mw [0:15];
   logic        ml [0:15];
   int          mu [0:15];
   int          slot_count = 0;
   int          mon_nbits  = 0;
   int          uf_pend    = 0;
   int          cur_uf     = 0;
   logic        mon_lr     = 1'b1;
   logic        prev_sclk  = 1'b0;
   logic [31:0] sh         = '0;

   always @(negedge clk) begin
      if (rst) begin
         mon_nbits <= 0;
         mon_lr    <= 1'b1;
         prev_sclk <= 1'b0;
         uf_pend   <= 0;
      end else begin
         prev_sclk <= sclk;
         if (sclk && !prev_sclk && lrclk != mon_lr) begin
            mon_lr    <= lrclk;
            mon_nbits <= 1;
            sh        <= {31'd0, sdo};
            cur_uf    <= uf_pend;
            uf_pend   <= underflow ? 1 : 0;
         end else begin
            if (underflow) uf_pend <= uf_pend + 1;
            if (sclk && !prev_sclk && mon_nbits != 0) begin
               sh <= {sh[30:0], sdo};
               if (mon_nbits == FB - 1) begin
                  if (slot_count < 16) begin
                     mw[slot_count] <= {sh[30:0], sdo};
                     ml[slot_count] <= mon_lr;
                     mu[slot_count] <= cur_uf;
                  end
                  slot_count <= slot_count + 1;
                  mon_nbits  <= 0;
               end else begin
                  mon_nbits <= mon_nbits + 1;
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic ch, input logic [DW-1:0] data, input string tag);
      tid    = {7'd0, ch};
      tdata  = data;
      tvalid = 1'b1;
      #1;
      check(tag, 32'(tready), 32'd1);
      @(negedge clk);
      tvalid = 1'b0;
   endtask

   // Returns on the first posedge after the monitor stored slot n-1.
   task automatic wait_slots(input int n);
      int t = 0;
      while (slot_count < n && t < 4000) begin
         @(posedge clk);
         t++;
      end
      check($sformatf("wait_slots_%0d", n), 32'(slot_count >= n), 32'd1);
   endtask

   task automatic check_slot(input int idx, input logic lr, input logic [DW-1:0] s, input int uf);
      logic [31:0] exp_w;
      exp_w = {1'b0, s, 7'd0};
      check($sformatf("slot%0d_word", idx), mw[idx], exp_w);
      check($sformatf("slot%0d_lr", idx), 32'(ml[idx]), 32'(lr));
      check($sformatf("slot%0d_uf", idx), 32'(mu[idx]), 32'(uf));
   endtask

   function automatic logic sig(input int w);
      case (w)
         0:       return sclk;
         1:       return sclk2;
         default: return lrclk2;
      endcase
   endfunction

   task automatic measure(input int which, output int period, output int high);
      logic v, pv;
      int   rises = 0;
      int   t0 = 0;
      period = -1;
      high   = -1;
      pv     = sig(which);
      for (int t = 0; t < 2000 && rises < 2; t++) begin
         @(negedge clk);
         v = sig(which);
         if (v && !pv) begin
            if (rises == 1) period = t - t0;
            t0 = t;
            rises++;
         end
         if (!v && pv && rises == 1) high = t - t0;
         pv = v;
      end
   endtask

   initial begin
      int t;
      int per, hi;
      tdata  = '0;
      tvalid = 1'b0;
      tid    = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_lrclk", 32'(lrclk), 32'd1);
      check("rst_sdo", 32'(sdo), 32'd0);
      check("rst_underflow", 32'(underflow), 32'd0);
      check("rst_tready_l", 32'(tready), 32'd1);
      tid = 8'd1;
      #1;
      check("rst_tready_r", 32'(tready), 32'd1);

      // Preload both channels, then look at the first frame.
      @(negedge clk);
      rst = 1'b0;
      send(1'b0, 24'hABCDEF, "preload_l");
      send(1'b1, 24'h123456, "preload_r");
      wait_slots(3);
      check_slot(0, 1'b0, 24'hABCDEF, 0);
      check_slot(1, 1'b1, 24'h123456, 0);
      check_slot(2, 1'b0, 24'h000000, 1);

      // Two left samples back to back during a right slot.
      @(negedge clk);
      send(1'b0, 24'h811111, "l1_accept");
      tid    = 8'd0;
      tdata  = 24'h7E2222;
      tvalid = 1'b1;
      #1;
      check("l2_stalled", 32'(tready), 32'd0);
      repeat (20) @(negedge clk);
      check("l2_still_stalled", 32'(tready), 32'd0);
      t = 0;
      while (!tready && t < 600) begin
         @(negedge clk);
         t++;
      end
      check("l2_released", 32'(tready), 32'd1);
      check("l2_release_lrclk", 32'(lrclk), 32'd0);
      check("l2_release_slots", 32'(slot_count), 32'd4);
      @(negedge clk);
      tvalid = 1'b0;

      // Left write landing exactly on the b=0 strobe of an empty left slot.
      wait_slots(8);
      check_slot(3, 1'b1, 24'h000000, 1);
      check_slot(4, 1'b0, 24'h811111, 0);
      check_slot(5, 1'b1, 24'h000000, 1);
      check_slot(6, 1'b0, 24'h7E2222, 0);
      check_slot(7, 1'b1, 24'h000000, 1);
      repeat (3) @(negedge clk);
      tid    = 8'd0;
      tdata  = 24'h5A5A5A;
      tvalid = 1'b1;
      @(negedge clk);
      tvalid = 1'b0;
      check("edge_underflow", 32'(underflow), 32'd1);
      check("edge_tready", 32'(tready), 32'd0);
      check("edge_lrclk", 32'(lrclk), 32'd0);

      // Queue a right sample for the slot that reset will cut short.
      wait_slots(10);
      @(negedge clk);
      send(1'b1, 24'h004000, "rx_accept");
      wait_slots(11);
      check_slot(8, 1'b0, 24'h000000, 1);
      check_slot(9, 1'b1, 24'h000000, 1);
      check_slot(10, 1'b0, 24'h5A5A5A, 0);
      @(negedge clk);
      send(1'b0, 24'hFFFFFF, "lx_accept");
      tid = 8'd0;
      t = 0;
      while (!(mon_lr == 1'b1 && mon_nbits == 11) && t < 2000) begin
         @(posedge clk);
         t++;
      end
      check("reach_b10", 32'(mon_nbits), 32'd11);
      @(negedge clk);
      check("b10_sdo", 32'(sdo), 32'd1);
      check("b10_lx_full", 32'(tready), 32'd0);
      rst = 1'b1;
      #1;
      check("abort_sclk", 32'(sclk), 32'd0);
      check("abort_lrclk", 32'(lrclk), 32'd1);
      check("abort_sdo", 32'(sdo), 32'd0);
      check("abort_underflow", 32'(underflow), 32'd0);
      check("abort_tready", 32'(tready), 32'd1);
      repeat (4) @(negedge clk);
      rst = 1'b0;

      // Restart with nothing buffered: every slot underflows with silence.
      wait_slots(13);
      check_slot(11, 1'b0, 24'h000000, 1);
      check_slot(12, 1'b1, 24'h000000, 1);

      // Clock shapes
      measure(0, per, hi);
      check("sclk_period_div4", 32'(per), 32'd8);
      check("sclk_high_div4", 32'(hi), 32'd4);
      measure(1, per, hi);
      check("sclk_period_div1", 32'(per), 32'd2);
      check("sclk_high_div1", 32'(hi), 32'd1);
      measure(2, per, hi);
      check("lrclk_period_div1", 32'(per), 32'd128);
      check("lrclk_high_div1", 32'(hi), 32'd64);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
